// File: rtl/nn_sched_if.sv
// rtl/nn_sched_if.sv - requester, engine and response signals of the nn_sched scheduler
// master is the scheduler side; slave is the requester/engine/consumer side.
interface nn_sched_if #(
  parameter int REQ_NUM      = 4,
  parameter int FEATURE_WIDE = 7,
  parameter int ID_W         = 2
);
  localparam int FW = FEATURE_WIDE + 6;
  localparam int LW = FEATURE_WIDE + 16;

  logic [REQ_NUM-1:0]    req;
  logic [REQ_NUM-1:0]    gnt;
  logic [REQ_NUM*FW-1:0] feat_in;
  logic [REQ_NUM-1:0]    feat_vld;
  logic [REQ_NUM-1:0]    feat_rdy;
  logic                  eng_rst_n;
  logic [FW-1:0]         eng_feature;
  logic                  eng_en;
  logic [LW-1:0]         eng_lab;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [LW-1:0]         rsp_lab;
  logic                  busy;

  modport master (
    input  req, feat_in, feat_vld, eng_lab, rsp_ready,
    output gnt, feat_rdy, eng_rst_n, eng_feature, eng_en,
           rsp_valid, rsp_id, rsp_lab, busy
  );

  modport slave (
    output req, feat_in, feat_vld, eng_lab, rsp_ready,
    input  gnt, feat_rdy, eng_rst_n, eng_feature, eng_en,
           rsp_valid, rsp_id, rsp_lab, busy
  );
endinterface

// File: rtl/nn_sched.sv
// rtl/nn_sched.sv - round-robin scheduler sharing one nn_top inference engine
// Per job: grant, one-cycle engine clear, stream FEATURE_NUM features, wait NN_LAT, return result.
module nn_sched #(
  parameter int REQ_NUM      = 4,
  parameter int FEATURE_WIDE = 7,
  parameter int FEATURE_NUM  = 7,
  parameter int NN_LAT       = 40,
  parameter int ID_W         = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  nn_sched_if.master bus
);
  localparam int FW = FEATURE_WIDE + 6;

  typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gidx;
  logic [4:0]      fcnt;
  logic [7:0]      lcnt;

  logic [2*REQ_NUM-1:0] req_dbl;
  logic [REQ_NUM-1:0]   req_rot;
  logic                 pick_vld;
  logic [ID_W-1:0]      pick_idx;
  int                   pick_off;
  int                   pick_sum;
  logic [FW-1:0]        sel_feat;
  logic                 beat;

  // Rotate req so that bit 0 is the rr_ptr position; the lowest set bit wins.
  always_comb begin
    req_dbl  = {bus.req, bus.req} >> rr_ptr;
    req_rot  = req_dbl[REQ_NUM-1:0];
    pick_vld = 1'b0;
    pick_off = 0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_off = k;
      end
    end
    pick_sum = int'(rr_ptr) + pick_off;
    if (pick_sum >= REQ_NUM) pick_sum = pick_sum - REQ_NUM;
    pick_idx = ID_W'(pick_sum);
  end

  always_comb begin
    sel_feat = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (gidx == ID_W'(i)) sel_feat = bus.feat_in[i*FW +: FW];
    end
    beat = (state == LOAD) && ((bus.feat_vld & bus.feat_rdy) != '0);
  end

  // Feature path is a pure pass-through so the engine sees the beat in the accepting cycle.
  assign bus.eng_en      = beat;
  assign bus.eng_feature = beat ? sel_feat : '0;
  assign bus.busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      gidx          <= '0;
      fcnt          <= '0;
      lcnt          <= '0;
      bus.gnt       <= '0;
      bus.feat_rdy  <= '0;
      bus.eng_rst_n <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_lab   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gidx          <= pick_idx;
            bus.gnt       <= REQ_NUM'(1) << pick_idx;
            bus.eng_rst_n <= 1'b0;
            state         <= CLR;
          end
        end
        CLR: begin
          bus.eng_rst_n <= 1'b1;
          bus.feat_rdy  <= bus.gnt;
          fcnt          <= '0;
          state         <= LOAD;
        end
        LOAD: begin
          if (beat) begin
            if (fcnt == 5'(FEATURE_NUM - 1)) begin
              fcnt         <= '0;
              lcnt         <= '0;
              bus.feat_rdy <= '0;
              state        <= WAIT;
            end else begin
              fcnt <= fcnt + 5'd1;
            end
          end
        end
        WAIT: begin
          // Capture lands NN_LAT edges after the last accepted beat.
          if (lcnt == 8'(NN_LAT - 1)) begin
            bus.rsp_lab   <= bus.eng_lab;
            bus.rsp_id    <= gidx;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            lcnt <= lcnt + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.gnt       <= '0;
            rr_ptr        <= (gidx == ID_W'(REQ_NUM - 1)) ? '0 : gidx + ID_W'(1);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nn_sched.md
Name: nn_sched

Overview:
- Round-robin scheduler that shares one nn_top inference engine among REQ_NUM sample requesters.
- Per job it does four things in order:
  - grants one requester;
  - clears the engine's feature counter through a dedicated engine reset;
  - streams that requester's FEATURE_NUM serial features into the engine;
  - waits the fixed engine latency, then returns the captured result tagged with the requester index.
- Sits between the sample sources and the nn_top instance, which owns the engine's rst_n and en.

Parameters:
- REQ_NUM, 4, number of requesters (2..8).
- FEATURE_WIDE, 7, engine feature integer width; feature word width FW = FEATURE_WIDE+6.
- FEATURE_NUM, 7, features per inference (1..16).
- NN_LAT, 40, cycles from last eng_en beat to valid eng_lab (1..255).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= REQ_NUM.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  REQ_NUM  per-requester job request (level)
- gnt  out  REQ_NUM  one-hot grant, held for whole job
- feat_in  in  REQ_NUM*FW  packed feature words, requester i at [i*FW +: FW]
- feat_vld  in  REQ_NUM  per-requester feature valid
- feat_rdy  out  REQ_NUM  per-requester feature ready
- eng_rst_n  out  1  engine reset (active-low)
- eng_feature  out  FW  feature to engine
- eng_en  out  1  feature strobe to engine
- eng_lab  in  FEATURE_WIDE+16  engine result
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  ID_W  index of requester owning result
- rsp_lab  out  FEATURE_WIDE+16  registered result
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, gnt=0, feat_rdy=0, eng_rst_n=1, eng_en=0, eng_feature=0, rsp_valid=0, rsp_id=0, rsp_lab=0, busy=0, counters=0.
- IDLE:
  - If req!=0, pick the first asserted req at index rr_ptr, rr_ptr+1, ... with wrap at REQ_NUM.
  - Register gnt one-hot and go to CLR. No req: stay.
- CLR: eng_rst_n=0 for exactly one cycle, then LOAD. This re-arms the engine's saturating input counter before every job.
- LOAD:
  - feat_rdy[g]=1 for the granted index g only.
  - eng_en = feat_vld[g] & feat_rdy[g]; eng_feature = feat_in slice g (combinational pass-through); eng_feature = 0 when eng_en=0.
  - fcnt counts accepted beats. Beat with fcnt==FEATURE_NUM-1 → WAIT, fcnt=0, lcnt=0.
  - feat_vld low stalls LOAD indefinitely; req deassertion does not abort a job.
- WAIT:
  - lcnt increments each cycle.
  - When lcnt==NN_LAT-1: capture eng_lab into rsp_lab, set rsp_id=g, rsp_valid=1, go to RESP.
  - Total cycles from last eng_en beat to rsp_valid rising = NN_LAT.
- RESP:
  - rsp_valid, rsp_lab and rsp_id are held stable until rsp_ready=1.
  - On handshake: rsp_valid=0, gnt=0, rr_ptr=(g+1) mod REQ_NUM, go to IDLE.
  - rsp_ready high on the first RESP cycle completes the handshake that cycle.
- Minimum turnaround between jobs: 2 cycles (RESP→IDLE→CLR). Grant evaluation happens only in IDLE.
- Requests arriving during a job are not lost as long as req is held; a requester must keep req high until granted.
- feat_vld on a non-granted requester is ignored; its feat_rdy stays 0.
- Asynchronous reset mid-job: everything returns to reset values, including eng_rst_n=1. The engine itself is also reset via the shared rst_n, and the partial job is dropped.
- Widths:
  - fcnt is 5 bits; lcnt is 8 bits.
  - rsp_id is zero-extended from the grant index.
  - No arithmetic on data paths: pure steering and registering.

Test Plan:
- Single job: req=0001, FEATURE_NUM=7 features 1..7 with feat_vld continuously high.
  → eng_rst_n low for exactly 1 cycle, then 7 eng_en beats carrying 1..7.
  → rsp_valid rises NN_LAT=40 cycles after the 7th beat with rsp_id=0; rsp_lab equals eng_lab sampled at that edge.
- Round robin: req=1111 held through four jobs → grant order 0,1,2,3. Then with rr_ptr=0 and req=1010 → grant 1, then 3.
- Stall: granted requester drops feat_vld for 5 cycles after beat 3.
  → no eng_en during the gap; state stays LOAD; beats 4..7 are delivered afterwards; latency is still measured from beat 7.
- Backpressure: rsp_ready held low for 10 cycles in RESP → rsp_valid/rsp_lab/rsp_id constant; req from another index is not granted until the handshake completes.
- Non-granted isolation: requester 2 drives feat_vld=1 while requester 0 is granted → feat_rdy[2]=0 throughout; eng_feature never carries requester 2 data.
- Reset mid-LOAD: rst_n pulsed low after 3 beats → all outputs at reset values; a new req=0100 starts a fresh job with a full 7-beat load.
